gf180mcu_fd_sc_mcu9t5v0__dlyline_prog: RTL
==========================================

Name: gf180mcu_fd_sc_mcu9t5v0__dlyline_prog

Overview:
- Clocked, programmable-depth delay line; parametrised successor to the fixed combinational delay buffer cell.
- Delays a WIDTH-bit bus by 0..MAXDLY clock cycles, with the delay selected at run time.
- Provides a clock enable and a VLD flag that marks when the selected delay line is fully primed.
- Used for cycle-exact skew alignment of data buses in the mcu9t5v0 digital flow.

Parameters:
- WIDTH, 4, data bus width in bits (>=1).
- MAXDLY, 8, number of register stages; maximum selectable delay (>=1).
- SW, $clog2(MAXDLY+1), width of SEL; derived, never overridden.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  shift enable; 0 freezes the stages and the fill counter.
- SEL  input  SW  requested delay in cycles; values above MAXDLY clamp to MAXDLY.
- I  input  WIDTH  data in.
- Z  output  WIDTH  delayed data out.
- VLD  output  1  1 when Z reflects a fully primed line at the current delay.

Behaviour:
- State:
  - tap[0..MAXDLY-1], each WIDTH bits.
  - sel_q, SW bits, holds the clamped SEL.
  - fill, SW bits, saturating counter.
- Reset (RN=0, asynchronous): all tap=0, sel_q=0, fill=0.
  - Consequently Z=I (bypass) and VLD=1 while in reset.
- sel_eff = (SEL > MAXDLY) ? MAXDLY : SEL.
- Each rising edge, RN=1:
  - If EN=1: tap[0]<=I and tap[k]<=tap[k-1] for k=1..MAXDLY-1.
  - If sel_eff != sel_q: sel_q<=sel_eff and fill<=0. This applies regardless of EN and overrides the fill increment.
  - Else if EN=1: fill <= min(fill+1, MAXDLY).
  - EN=0 with no SEL change: taps and fill hold.
- Outputs are combinational from state and I:
  - Z = (sel_q==0) ? I : tap[sel_q-1].
  - VLD = (fill >= sel_q).
- Delay rules:
  - With sel_q=N>0 and EN held at 1, Z at cycle t equals I sampled at the edge N cycles earlier.
  - Latency is N clocks; delay 0 is a purely combinational path.
- SEL change timing:
  - A change takes effect on the next edge, so Z switches taps one cycle after SEL moves.
  - VLD drops to 0 at that edge, unless the new sel_q is 0.
  - VLD returns to 1 after sel_q further enabled edges.
  - Tap contents are not flushed on a SEL change, so stale data may appear on Z while VLD=0.
- Saturation: fill stops at MAXDLY, so VLD stays 1 indefinitely.
- Reset mid-operation: all state clears immediately, with no dependence on CLK. The first edge after RN rises behaves as a normal edge.
- SEL=MAXDLY uses tap[MAXDLY-1]; no out-of-range tap index is possible.

Test Plan (WIDTH=4, MAXDLY=8):
- Reset, SEL=0: RN=0, I=4'hA -> Z=4'hA, VLD=1. Release RN, I=4'h5 -> Z=4'h5 in the same cycle.
- Fixed delay: SEL=3, EN=1, I=1,2,3,... on consecutive edges.
  - One edge after SEL=3: sel_q=3, VLD=0.
  - After 3 further edges: VLD=1, and Z thereafter equals I from 3 edges earlier (I=7 sampled -> Z=7 three edges later).
- Enable gating: mid-stream with SEL=3, hold EN=0 for 5 cycles -> Z and VLD are frozen. Set EN=1 -> the sequence resumes with no lost or duplicated sample.
- Clamp: SEL=12 -> sel_q=8. Z=I delayed 8 cycles, and VLD rises after 8 enabled edges.
- SEL change mid-stream: primed at SEL=3, switch to SEL=5.
  - Next edge: VLD=0 and Z=tap[4].
  - After 5 further enabled edges: VLD=1.
  - Switching back to SEL=0 -> Z=I and VLD=1 after one edge.
- Reset mid-operation: SEL=4, line primed, pulse RN=0 between edges.
  - Immediately: Z=I, VLD=1, taps=0.
  - After release, with SEL still 4: the first edge sets sel_q=4 and VLD=0, and the first Z values after the switch are 0.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline_prog.sv
// Programmable-depth clocked delay line.
// The WIDTH-bit bus I is delayed by 0..MAXDLY enabled clock edges, chosen at run time by SEL.
// VLD reports when every stage feeding the selected tap has been refilled since the last delay change.
module gf180mcu_fd_sc_mcu9t5v0__dlyline_prog #(
  parameter  int WIDTH  = 4,
  parameter  int MAXDLY = 8,
  localparam int SW     = $clog2(MAXDLY + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [SW-1:0]    SEL,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Z,
  output logic             VLD
);

  localparam logic [SW-1:0] MAX_SEL = SW'(MAXDLY);

  logic [WIDTH-1:0] tap_reg [MAXDLY];
  logic [SW-1:0]    sel_q_reg;
  logic [SW-1:0]    fill_reg;
  logic [SW-1:0]    sel_eff;
  logic [SW-1:0]    fill_next;

  // Requests beyond the physical line length fall back to the deepest tap.
  assign sel_eff = (SEL > MAX_SEL) ? MAX_SEL : SEL;

  // The fill counter saturates at the line length, so VLD stays high indefinitely.
  assign fill_next = (fill_reg == MAX_SEL) ? fill_reg : fill_reg + SW'(1);

  // Shift register: every enabled edge pushes I in at tap 0 and moves older samples one stage deeper.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int k = 0; k < MAXDLY; k++) begin
        tap_reg[k] <= '0;
      end
    end else if (EN) begin
      tap_reg[0] <= I;
      for (int k = 1; k < MAXDLY; k++) begin
        tap_reg[k] <= tap_reg[k-1];
      end
    end
  end

  // Delay select and fill tracking. A delay change restarts the fill count even while EN is low,
  // because the stages feeding the new tap have not been verified as filled.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sel_q_reg <= '0;
      fill_reg  <= '0;
    end else if (sel_eff != sel_q_reg) begin
      sel_q_reg <= sel_eff;
      fill_reg  <= '0;
    end else if (EN) begin
      fill_reg  <= fill_next;
    end
  end

  // Output tap mux. Delay 0 is a combinational bypass, and delay N reads tap N-1.
  always_comb begin
    Z = I;
    for (int k = 0; k < MAXDLY; k++) begin
      if (sel_q_reg == SW'(k + 1)) begin
        Z = tap_reg[k];
      end
    end
  end

  assign VLD = (fill_reg >= sel_q_reg);

endmodule
